// File: rtl/insn_fetch_sequencer.sv
// Purpose: fetch/sequencing stage that owns the PC and steps each instruction through FETCH, DECODE, EXEC and WB.
// Latency: 4 cycles minimum per instruction (one FETCH cycle with an immediate mem_ready), plus memory wait and stall cycles.
// Backpressure: stall holds the instruction in DECODE; a fetch gives up after TIMEOUT cycles without mem_ready.
module insn_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        pc_next_sel,
    input  logic [31:0] pc_target,
    input  logic        stall,
    output logic [31:0] INSN,
    output logic        insn_valid,
    output logic        exec_en,
    output logic [31:0] PC,
    output logic [1:0]  state,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    // Last FETCH cycle index before the fetch is abandoned.
    localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] insn_q, insn_d;
    logic        err_q, err_d;
    // Low for the first cycle out of reset so mem_req only rises after the first edge.
    logic        run_q;

    // Sequencer state registers; reset also kills exec_en immediately via state_q.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_FETCH;
            cnt_q   <= 8'd0;
            pc_q    <= RESET_PC;
            insn_q  <= NOP_INSN;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            insn_q  <= insn_d;
            err_q   <= err_d;
            run_q   <= 1'b1;
        end
    end

    // Next-state, timeout counting, instruction capture and PC selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        insn_d  = insn_q;
        err_d   = err_q;
        unique case (state_q)
            ST_FETCH: begin
                if (run_q) begin
                    if (mem_ready) begin
                        // A response on the limit cycle still wins over the timeout.
                        insn_d  = mem_rdata;
                        cnt_d   = 8'd0;
                        state_d = ST_DECODE;
                    end else if (cnt_q == CNT_LIMIT) begin
                        insn_d  = NOP_INSN;
                        err_d   = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = ST_DECODE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_DECODE: begin
                if (!stall) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_WB;
            end
            ST_WB: begin
                if (pc_next_sel) begin
                    // Misaligned targets are forced to word alignment and flagged.
                    pc_d = pc_target & ~32'h3;
                    if (pc_target[1:0] != 2'b00) begin
                        err_d = 1'b1;
                    end
                end else begin
                    pc_d = pc_q + 32'd4;
                end
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    assign mem_req    = (state_q == ST_FETCH) && run_q;
    assign mem_addr   = pc_q;
    assign PC         = pc_q;
    assign INSN       = insn_q;
    assign insn_valid = (state_q != ST_FETCH);
    assign exec_en    = (state_q == ST_EXEC);
    assign state      = state_q;
    assign fetch_err  = err_q;

endmodule

// File: doc/insn_fetch_sequencer.md
Name: insn_fetch_sequencer

Overview:
- Fetch/sequencing stage directly upstream of the per-type instruction decoders.
- Owns the program counter, issues instruction reads to memory, latches the returned word into the instruction register and presents it as INSN to the decoders.
- Generates the one-cycle execute window in which the decoders' rd_clk/mem_clk strobes are allowed to fire.
- Consumes the decoders' pc_next_sel together with the ALU target to compute the next PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, maximum cycles to wait for mem_ready before aborting a fetch (range 2..255).
- NOP_INSN, 32'h0000_0013, word loaded into INSN on a fetch timeout (addi x0,x0,0).

Ports:
- CLK  in  1  processor clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- mem_rdata  in  32  instruction word from memory.
- mem_ready  in  1  memory has valid mem_rdata this cycle.
- mem_req  out  1  instruction read request.
- mem_addr  out  32  instruction read address (= PC).
- pc_next_sel  in  1  from decoder: 0 = PC+4, 1 = pc_target.
- pc_target  in  32  branch/jump target from ALU.
- stall  in  1  hold the current instruction in DECODE.
- INSN  out  32  instruction register, feeds the decoders.
- insn_valid  out  1  INSN holds a fetched, not-yet-retired instruction.
- exec_en  out  1  one-cycle execute strobe; decoder clock outputs are gated by it.
- PC  out  32  address of the instruction in INSN.
- state  out  2  FSM state encoding, for debug.
- fetch_err  out  1  sticky error flag: timeout or misaligned target.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - PC=RESET_PC, INSN=NOP_INSN, state=FETCH.
  - mem_req=0, insn_valid=0, exec_en=0, fetch_err=0, timeout counter=0.
  - mem_req rises on the first CLK edge after RST_N deasserts.
- FSM states: FETCH=2'd0, DECODE=2'd1, EXEC=2'd2, WB=2'd3.
- FETCH:
  - mem_req=1, mem_addr=PC; the counter increments each cycle.
  - mem_ready=1: INSN<=mem_rdata, counter<=0, go to DECODE.
  - Counter reaches TIMEOUT-1 with mem_ready=0: INSN<=NOP_INSN, fetch_err<=1, counter<=0, go to DECODE.
  - mem_ready arriving in the same cycle as the timeout limit counts as success.
- DECODE:
  - mem_req=0, insn_valid=1.
  - stall=1: remain in DECODE; INSN and PC held.
  - stall=0: go to EXEC.
- EXEC:
  - exec_en=1 for exactly this cycle; insn_valid=1. stall is ignored.
  - Always go to WB.
- WB:
  - insn_valid=1, exec_en=0.
  - PC update at the end of WB: pc_next_sel=0 gives PC<=PC+4 (mod 2^32, wraps 32'hFFFF_FFFC→0). pc_next_sel=1 gives PC<=pc_target.
  - If pc_target[1:0]!=0 with pc_next_sel=1: PC<=pc_target & ~32'h3 and fetch_err<=1.
  - Go to FETCH.
- All outputs are registered or decoded from state; no combinational path from inputs to outputs except mem_addr=PC.
- Minimum instruction period is 4 cycles: 1 FETCH with immediate mem_ready, plus DECODE, EXEC, WB.
- fetch_err is sticky; only RST_N clears it. An error does not halt sequencing.
- Reset asserted mid-fetch or mid-EXEC:
  - Immediate return to reset values.
  - exec_en drops asynchronously, so no partial register write is strobed.
  - A pending memory response is discarded.
- pc_next_sel and pc_target are sampled only in WB.

Test Plan:
- Reset release, RESET_PC=0, memory with mem_ready tied 1 returning 32'h0000_0517 (auipc) → mem_addr sequence 0,4,8 at 4-cycle spacing; exec_en high once per instruction; INSN=32'h0000_0517 during DECODE/EXEC/WB.
- mem_ready delayed 3 cycles → FETCH lasts 4 cycles; INSN captured on the cycle mem_ready=1; fetch_err stays 0.
- mem_ready never asserted, TIMEOUT=16 → after 16 FETCH cycles INSN=32'h0000_0013, fetch_err=1, next mem_addr=PC+4.
- pc_next_sel=1, pc_target=32'h0000_0100 in WB → next mem_addr=32'h100. Repeat with pc_target=32'h0000_0102 → mem_addr=32'h100, fetch_err=1.
- stall=1 for 5 cycles in DECODE → state=DECODE, exec_en=0 for 5 cycles, INSN/PC unchanged; EXEC occurs on the cycle after stall drops.
- RST_N pulsed low during EXEC with PC=32'h0000_0040 → exec_en=0 immediately, PC=RESET_PC, fetch_err=0, fetch restarts at RESET_PC.
- PC=32'hFFFF_FFFC, pc_next_sel=0 → next mem_addr=0.
